tstate_sequencer: RTL



---
 rtl/cpu_ctrl_pkg.sv | 23 ++
 rtl/tstate_decoder.sv | 29 ++
 rtl/tstate_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the RISC CPU control unit.
//   ts_state_e : T-state sequencer operating state (RUN / HALTED)
//   T0..T7     : T-state index constants used by control-signal decoding
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

    typedef enum logic {
        TS_RUN    = 1'b0,
        TS_HALTED = 1'b1
    } ts_state_e;

    localparam int unsigned T0 = 0;
    localparam int unsigned T1 = 1;
    localparam int unsigned T2 = 2;
    localparam int unsigned T3 = 3;
    localparam int unsigned T4 = 4;
    localparam int unsigned T5 = 5;
    localparam int unsigned T6 = 6;
    localparam int unsigned T7 = 7;

endpackage : cpu_ctrl_pkg

// File: rtl/tstate_decoder.sv
// -----------------------------------------------------------------------------
// tstate_decoder
// Purely combinational binary-to-one-hot decoder with enable.
// Ports:
//   idx_i    [CNT_W-1:0] : binary step index
//   en_i                 : when low, all outputs are zero
//   onehot_o [NUM_T-1:0] : onehot_o[idx_i] = en_i; indices >= NUM_T give zero
// -----------------------------------------------------------------------------
module tstate_decoder #(
    parameter int unsigned NUM_T = 8,
    parameter int unsigned CNT_W = 3
) (
    input  logic [CNT_W-1:0] idx_i,
    input  logic             en_i,
    output logic [NUM_T-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            for (int unsigned i = 0; i < NUM_T; i++) begin
                if (idx_i == CNT_W'(i)) begin
                    onehot_o[i] = 1'b1;
                end
            end
        end
    end

endmodule : tstate_decoder

// File: rtl/tstate_sequencer.sv
// -----------------------------------------------------------------------------
// tstate_sequencer
// Control-unit timing generator: steps a counter through T0..T[eff_last]
// and presents it as a one-hot T-state strobe, with sync clear, stall,
// halt/resume and a count of completed sequences.
// Ports:
//   clk        : system clock, rising edge
//   reset      : asynchronous active-high reset
//   clr        : synchronous restart to T0
//   stall      : hold current T-state
//   halt       : enter HALTED
//   resume     : leave HALTED (ignored if halt is also high)
//   last_t     : index of the final T-state (clamped to NUM_T-1)
//   count      : current step index
//   t_onehot   : one-hot T-state strobe, all zero while halted
//   t_last     : current step is terminal (RUN only)
//   halted     : HALTED state indicator
//   instr_cnt  : completed sequences, wraps modulo 2**ICNT_W
// -----------------------------------------------------------------------------
module tstate_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned NUM_T  = 8,
    parameter int unsigned CNT_W  = 3,
    parameter int unsigned ICNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              stall,
    input  logic              halt,
    input  logic              resume,
    input  logic [CNT_W-1:0]  last_t,
    output logic [CNT_W-1:0]  count,
    output logic [NUM_T-1:0]  t_onehot,
    output logic              t_last,
    output logic              halted,
    output logic [ICNT_W-1:0] instr_cnt
);

    // Elaboration-time parameter sanity.
    if (NUM_T < 2 || NUM_T > 64) begin : g_bad_num_t
        $error("tstate_sequencer: NUM_T must be in 2..64");
    end
    if ((64'd1 << CNT_W) < 64'(NUM_T)) begin : g_bad_cnt_w
        $error("tstate_sequencer: CNT_W too small for NUM_T");
    end

    localparam logic [CNT_W-1:0] LAST_MAX = CNT_W'(NUM_T - 1);

    ts_state_e         state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ICNT_W-1:0] icnt_q,  icnt_d;

    logic [CNT_W-1:0]  eff_last;
    logic              at_last;
    logic              run;

    // Clamp only when the counter can represent indices beyond NUM_T-1;
    // otherwise the comparison would be constant.
    if ((64'd1 << CNT_W) > 64'(NUM_T)) begin : g_clamp
        assign eff_last = (last_t > LAST_MAX) ? LAST_MAX : last_t;
    end else begin : g_noclamp
        assign eff_last = last_t;
    end

    assign run = (state_q == TS_RUN);

    // >= rather than == so a last_t lowered below the current step still
    // terminates the sequence on the next advance.
    assign at_last = (count_q >= eff_last);

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= TS_RUN;
            count_q <= '0;
            icnt_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            icnt_q  <= icnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        icnt_d  = icnt_q;

        unique case (state_q)
            TS_RUN: begin
                if (halt) begin
                    state_d = TS_HALTED;
                    count_d = '0;
                end else if (clr) begin
                    count_d = '0;
                end else if (stall) begin
                    count_d = count_q;
                end else if (at_last) begin
                    count_d = '0;
                    icnt_d  = icnt_q + ICNT_W'(1);
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end

            TS_HALTED: begin
                count_d = '0;
                if (resume && !halt) begin
                    state_d = TS_RUN;
                end
            end

            default: begin
                state_d = TS_RUN;
                count_d = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    tstate_decoder #(
        .NUM_T (NUM_T),
        .CNT_W (CNT_W)
    ) u_decoder (
        .idx_i    (count_q),
        .en_i     (run),
        .onehot_o (t_onehot)
    );

    assign count     = count_q;
    assign t_last    = run && at_last;
    assign halted    = (state_q == TS_HALTED);
    assign instr_cnt = icnt_q;

endmodule : tstate_sequencer
